// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline state types and helpers
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Number of entries held in a given stage state.
    function automatic logic [1:0] state_occupancy(stage_state_e st);
        case (st)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle around one elastic pipeline stage
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Advance on each event and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry elastic pipeline register with flush and stall counter
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    // in_ready depends on state alone, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : '0;
    assign occupancy = state_occupancy(state_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Next state and entry moves; flush overrides everything and drops any same-cycle input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // State and entry registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk;
    logic             nrst;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_reg_if #(.DATA_W(DATA_W)) ifc ();

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (clk),
        .nRST      (nrst),
        .in_valid  (ifc.in_valid),
        .in_ready  (ifc.in_ready),
        .in_data   (ifc.in_data),
        .flush     (ifc.flush),
        .out_valid (ifc.out_valid),
        .out_ready (ifc.out_ready),
        .out_data  (ifc.out_data),
        .occupancy (ifc.occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks;
    int               n_fail;
    logic [127:0]     exp_q[$];
    logic [CNT_W-1:0] exp_stall;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model state (outputs must be settled).
    task automatic check_outputs(input string tag);
        int unsigned sz;
        logic [127:0] exp_data;
        sz = exp_q.size();
        exp_data = (sz > 0) ? exp_q[0] : 128'd0;
        check_val({tag, ".in_ready"},  128'(ifc.in_ready),  128'(sz < 2));
        check_val({tag, ".out_valid"}, 128'(ifc.out_valid), 128'(sz > 0));
        check_val({tag, ".occupancy"}, 128'(ifc.occupancy), 128'(sz));
        check_val({tag, ".out_data"},  128'(ifc.out_data),  exp_data);
        check_val({tag, ".stall_cnt"}, 128'(stall_cnt),     128'(exp_stall));
    endtask

    // Called at a falling edge: drive, check just before the rising edge, update model.
    task automatic cycle(input string tag, input logic iv, input logic [127:0] id,
                         input logic ordy, input logic fl);
        logic in_fire;
        logic out_fire;
        int unsigned sz;
        ifc.in_valid  = iv;
        ifc.in_data   = id;
        ifc.out_ready = ordy;
        ifc.flush     = fl;
        #4;
        check_outputs(tag);
        sz = exp_q.size();
        in_fire  = iv && (sz < 2);
        out_fire = (sz > 0) && ordy;
        if ((sz > 0) && !ordy && (exp_stall != CNT_MAX)) exp_stall = exp_stall + 1'b1;
        if (out_fire) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (in_fire) exp_q.push_back(id);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        nrst = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b0;
        exp_q.delete();
        exp_stall = '0;
        @(negedge clk);
        check_outputs("reset");
        nrst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b1;
        exp_stall = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b0;
        @(negedge clk);
        reset_dut();

        // Single transfer
        cycle("single_in", 1'b1, 128'hA5, 1'b1, 1'b0);
        check_val("single_out", 128'(ifc.out_data), 128'hA5);
        cycle("single_drain", 1'b0, 128'h0, 1'b1, 1'b0);
        cycle("single_idle", 1'b0, 128'h0, 1'b1, 1'b0);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, 128'(i), 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, 128'h0, 1'b1, 1'b0);
        cycle("stream_idle", 1'b0, 128'h0, 1'b1, 1'b0);

        // Backpressure: fill, offer while full, then release
        cycle("bp_a", 1'b1, 128'h11, 1'b0, 1'b0);
        cycle("bp_b", 1'b1, 128'h22, 1'b0, 1'b0);
        cycle("bp_full", 1'b1, 128'h99, 1'b0, 1'b0);
        cycle("bp_hold", 1'b0, 128'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, 128'h0, 1'b1, 1'b0);

        // Flush in FULL with a competing input
        reset_dut();
        cycle("fl_a", 1'b1, 128'h44, 1'b0, 1'b0);
        cycle("fl_b", 1'b1, 128'h55, 1'b0, 1'b0);
        cycle("fl_full", 1'b1, 128'h33, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("fl_after", 1'b0, 128'h0, 1'b1, 1'b0);

        // Flush in ONE alongside an output transfer and an input offer
        cycle("flo_a", 1'b1, 128'h66, 1'b0, 1'b0);
        cycle("flo_fl", 1'b1, 128'h77, 1'b1, 1'b1);
        cycle("flo_after", 1'b0, 128'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) cycle("rand_drain", 1'b0, 128'h0, 1'b1, 1'b0);

        // Stall counter saturation
        reset_dut();
        cycle("sat_fill", 1'b1, 128'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b0, 128'h0, 1'b0, 1'b0);
        check_val("sat_final", 128'(stall_cnt), 128'(CNT_MAX));

        // Asynchronous reset while FULL
        cycle("ar_a", 1'b1, 128'hAA, 1'b0, 1'b0);
        cycle("ar_b", 1'b1, 128'hBB, 1'b0, 1'b0);
        check_val("ar_pre_occ", 128'(ifc.occupancy), 128'd2);
        #2;
        nrst = 1'b0;
        ifc.in_valid = 1'b0;
        exp_q.delete();
        exp_stall = '0;
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        nrst = 1'b1;
        cycle("ar_first", 1'b1, 128'hCC, 1'b1, 1'b0);
        cycle("ar_next", 1'b0, 128'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
